// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bus controller.
//   state_t        : controller FSM states
//   SZ_*           : whb access-size encodings (2'b11 is handled as a word)
//   BE_*           : byte-enable patterns for half/word stores
//   is_misaligned  : true when an access does not sit on its natural boundary
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_LO  = 4'b0011;
    localparam logic [3:0] BE_HI  = 4'b1100;
    localparam logic [3:0] BE_ALL = 4'b1111;

    // Size 2'b11 falls into the default branch, so it is checked like a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data-memory controller (purely combinational).
//   Store side : st_size/st_off/st_data -> replicated st_wdata and st_be
//   Load side  : ld_size/ld_off/ld_su/ld_rdata -> extracted, extended ld_data
// The two sides take separate inputs because stores are steered from the live
// MEM-stage request while loads are extracted using the registered request.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_su,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Store data is replicated across every lane so the memory only needs the
    // byte enables to pick the right bytes.
    always_comb begin
        st_wdata = st_data;
        st_be    = BE_ALL;
        case (st_size)
            SZ_BYTE: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = 4'b0001 << st_off;
            end
            SZ_HALF: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = st_off[1] ? BE_HI : BE_LO;
            end
            default: begin
                st_wdata = st_data;
                st_be    = BE_ALL;
            end
        endcase
    end

    // Load lane selection, then sign (su=0) or zero (su=1) extension.
    always_comb begin
        lane_b  = ld_rdata[7:0];
        lane_h  = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data = ld_rdata;
        case (ld_off)
            2'd0: lane_b = ld_rdata[7:0];
            2'd1: lane_b = ld_rdata[15:8];
            2'd2: lane_b = ld_rdata[23:16];
            default: lane_b = ld_rdata[31:24];
        endcase
        case (ld_size)
            SZ_BYTE: ld_data = ld_su ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_HALF: ld_data = ld_su ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory bus controller sitting directly after the MEM stage.
//   clk, rst (async, active low)
//   MEM side : cs_d_n, rd, wr, d_addr, Data_write, whb, su  -> stall, Data_read,
//              misalign, bus_err
//   Bus side : mem_req, mem_we, mem_addr, mem_wdata, mem_be  <- mem_ack, mem_rdata
// An aligned access runs IDLE -> REQ (until ack or timeout) -> DONE -> IDLE.
// The core is stalled in IDLE (combinationally) and throughout REQ; DONE
// releases it for one cycle and deliberately ignores the still-present request.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_d_n,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] Data_write,
    input  logic [1:0]  whb,
    input  logic        su,
    output logic        stall,
    output logic [31:0] Data_read,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_t state, next_state;

    logic [CNT_W-1:0] cnt;
    logic             rd_on, wr_on, access, mis, go;
    logic             acked, timed_out;
    logic [1:0]       ld_off, ld_size;
    logic             ld_su;
    logic [31:0]      st_wdata, ld_data;
    logic [3:0]       st_be;

    // Strobes count only when they are a clean 1; z or x from an undriven
    // MEM-stage net must not start a transaction.
    assign rd_on  = (rd === 1'b1);
    assign wr_on  = (wr === 1'b1);
    assign access = !cs_d_n && (rd_on ^ wr_on);
    assign mis    = is_misaligned(whb, d_addr[1:0]);
    // Gating with rst keeps stall low while reset is held, even with a live request.
    assign go     = rst && access && !mis;

    dmem_lane_align u_align (
        .st_size  (whb),
        .st_off   (d_addr[1:0]),
        .st_data  (Data_write),
        .st_wdata (st_wdata),
        .st_be    (st_be),
        .ld_size  (ld_size),
        .ld_off   (ld_off),
        .ld_su    (ld_su),
        .ld_rdata (mem_rdata),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // mem_req comes straight from the state so an async reset drops it at once.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        mem_req    = 1'b0;
        acked      = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    stall      = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    acked      = 1'b1;
                    next_state = DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    timed_out  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request capture, timeout counter, status pulses and the load result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            ld_off    <= '0;
            ld_size   <= '0;
            ld_su     <= 1'b0;
            Data_read <= '0;
        end else begin
            misalign <= (state == IDLE) && access && mis;
            bus_err  <= timed_out;
            if (state == REQ) cnt <= cnt + CNT_W'(1);
            else              cnt <= '0;
            if (state == IDLE && go) begin
                mem_we    <= wr_on;
                mem_addr  <= {d_addr[31:2], 2'b00};
                mem_wdata <= st_wdata;
                mem_be    <= st_be;
                ld_off    <= d_addr[1:0];
                ld_size   <= whb;
                ld_su     <= su;
            end
            if (acked && !mem_we)
                Data_read <= ld_data;
            else if (timed_out && !mem_we)
                Data_read <= '0;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: each transaction pushes its expected bus
// view and result into a queue; the entry is popped and compared when the
// controller reaches its release cycle.
module tb_dmem_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs_d_n = 1'b1, rd = 1'b0, wr = 1'b0, su = 1'b0;
    logic [31:0] d_addr = '0, Data_write = '0, mem_rdata = '0;
    logic [1:0]  whb = 2'b00;
    logic        mem_ack = 1'b0;
    logic        stall, misalign, bus_err, mem_req, mem_we;
    logic [31:0] Data_read, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_dr = '0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] dr;
        logic        berr;
        int          req_n;
        int          stall_n;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .cs_d_n(cs_d_n), .rd(rd), .wr(wr),
        .d_addr(d_addr), .Data_write(Data_write), .whb(whb), .su(su),
        .stall(stall), .Data_read(Data_read), .misalign(misalign), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", tag, act, expv);
        end
    endtask

    // Reference behaviour written with shifts/multiplies rather than lane muxes.
    function automatic exp_t model(input logic is_wr, input logic [31:0] addr, input logic [31:0] data,
                                   input logic [1:0] size, input logic usu, input logic [31:0] rdata,
                                   input int waits, input bit do_ack, input logic [31:0] prev_dr);
        exp_t e;
        logic [31:0] sh;
        logic signed [7:0] sb;
        logic signed [15:0] shw;
        int sv;
        logic [1:0] sz;
        sz = (size == 2'b11) ? 2'b10 : size;
        sh = rdata >> (8 * addr[1:0]);
        e.we   = is_wr;
        e.addr = addr & 32'hFFFF_FFFC;
        e.berr = !do_ack;
        e.req_n = do_ack ? waits + 1 : TMO;
        e.stall_n = e.req_n + 1;
        case (sz)
            2'b00: begin e.wdata = data[7:0] * 32'h0101_0101;  e.be = 4'(1 << addr[1:0]); end
            2'b01: begin e.wdata = data[15:0] * 32'h0001_0001; e.be = addr[1] ? 4'hC : 4'h3; end
            default: begin e.wdata = data; e.be = 4'hF; end
        endcase
        if (is_wr) e.dr = prev_dr;
        else if (!do_ack) e.dr = 32'h0;
        else begin
            case (sz)
                2'b00: begin
                    sb = sh[7:0]; sv = sb;
                    e.dr = usu ? (sh & 32'hFF) : sv;
                end
                2'b01: begin
                    shw = sh[15:0]; sv = shw;
                    e.dr = usu ? (sh & 32'hFFFF) : sv;
                end
                default: e.dr = rdata;
            endcase
        end
        return e;
    endfunction

    // Runs one aligned transaction; acks after 'waits' REQ cycles (or never).
    task automatic applyStimulus(input string name, input logic is_wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [1:0] size, input logic usu,
                                 input logic [31:0] rdata, input int waits, input bit do_ack);
        exp_t e;
        int stall_n = 0;
        int req_n = 0;
        bit seen_req = 0;
        bit done = 0;
        bit unstable = 0;
        logic [31:0] a0 = '0, w0 = '0;
        logic [3:0] b0 = '0;
        logic we0 = 1'b0;
        e = model(is_wr, addr, data, size, usu, rdata, waits, do_ack, model_dr);
        model_dr = e.dr;
        exp_q.push_back(e);
        @(negedge clk);
        cs_d_n = 1'b0; rd = ~is_wr; wr = is_wr; d_addr = addr; Data_write = data;
        whb = size; su = usu; mem_rdata = rdata; mem_ack = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            if (stall) stall_n++;
            if (mem_req) begin
                req_n++;
                if (!seen_req) begin
                    seen_req = 1; a0 = mem_addr; w0 = mem_wdata; b0 = mem_be; we0 = mem_we;
                end else if (a0 !== mem_addr || w0 !== mem_wdata || b0 !== mem_be || we0 !== mem_we) begin
                    unstable = 1;
                end
                mem_ack = do_ack && (req_n > waits);
            end else begin
                mem_ack = 1'b0;
                if (seen_req) done = 1;
            end
            if (!done) @(negedge clk);
        end
        mem_ack = 1'b0;
        if (!done) checkOutput({name, "_bound"}, 32'd0, 32'd1);
        e = exp_q.pop_front();
        checkOutput({name, "_we"},      {31'b0, mem_we}, {31'b0, e.we});
        checkOutput({name, "_addr"},    mem_addr, e.addr);
        checkOutput({name, "_be"},      {28'b0, mem_be}, {28'b0, e.be});
        if (e.we) checkOutput({name, "_wdata"}, mem_wdata, e.wdata);
        checkOutput({name, "_dread"},   Data_read, e.dr);
        checkOutput({name, "_buserr"},  {31'b0, bus_err}, {31'b0, e.berr});
        checkOutput({name, "_reqcyc"},  req_n, e.req_n);
        checkOutput({name, "_stallcyc"}, stall_n, e.stall_n);
        checkOutput({name, "_stable"},  {31'b0, unstable}, 32'd0);
        cs_d_n = 1'b1; rd = 1'b0; wr = 1'b0;
        @(negedge clk); #1;
        checkOutput({name, "_berr_clr"}, {31'b0, bus_err}, 32'd0);
        checkOutput({name, "_idle_req"}, {31'b0, mem_req}, 32'd0);
    endtask

    task automatic checkMisalign(input string name, input logic is_wr, input logic [31:0] addr,
                                 input logic [1:0] size);
        @(negedge clk);
        cs_d_n = 1'b0; rd = ~is_wr; wr = is_wr; d_addr = addr; whb = size; su = 1'b0;
        #1;
        checkOutput({name, "_stall"}, {31'b0, stall}, 32'd0);
        @(negedge clk); #1;
        checkOutput({name, "_pulse"}, {31'b0, misalign}, 32'd1);
        checkOutput({name, "_req"},   {31'b0, mem_req}, 32'd0);
        checkOutput({name, "_dread"}, Data_read, model_dr);
        cs_d_n = 1'b1; rd = 1'b0; wr = 1'b0;
        @(negedge clk); #1;
        checkOutput({name, "_pulse_end"}, {31'b0, misalign}, 32'd0);
    endtask

    initial begin
        #2;
        checkOutput("rst_stall",  {31'b0, stall}, 32'd0);
        checkOutput("rst_dread",  Data_read, 32'd0);
        checkOutput("rst_mis",    {31'b0, misalign}, 32'd0);
        checkOutput("rst_berr",   {31'b0, bus_err}, 32'd0);
        checkOutput("rst_req",    {31'b0, mem_req}, 32'd0);
        checkOutput("rst_we",     {31'b0, mem_we}, 32'd0);
        checkOutput("rst_addr",   mem_addr, 32'd0);
        checkOutput("rst_wdata",  mem_wdata, 32'd0);
        checkOutput("rst_be",     {28'b0, mem_be}, 32'd0);
        @(negedge clk); rst = 1'b1;

        applyStimulus("wst",    1'b1, 32'h100, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 0, 1'b1);
        applyStimulus("lbs",    1'b0, 32'h203, 32'h0,         2'b00, 1'b0, 32'h80FF_1234, 0, 1'b1);
        applyStimulus("lbu",    1'b0, 32'h203, 32'h0,         2'b00, 1'b1, 32'h80FF_1234, 0, 1'b1);
        applyStimulus("lhu",    1'b0, 32'h302, 32'h0,         2'b01, 1'b1, 32'hBEEF_0001, 3, 1'b1);
        applyStimulus("shst",   1'b1, 32'h106, 32'h1234_ABCD, 2'b01, 1'b0, 32'h0, 1, 1'b1);
        applyStimulus("sbst",   1'b1, 32'h101, 32'h0000_005A, 2'b00, 1'b0, 32'h0, 2, 1'b1);
        applyStimulus("lhs",    1'b0, 32'h300, 32'h0,         2'b01, 1'b0, 32'h1234_8001, 0, 1'b1);
        applyStimulus("lw11",   1'b0, 32'h40C, 32'h0,         2'b11, 1'b0, 32'hCAFE_F00D, 1, 1'b1);

        checkMisalign("mis_w", 1'b0, 32'h401, 2'b10);
        checkMisalign("mis_h", 1'b1, 32'h403, 2'b01);

        applyStimulus("tmo",    1'b0, 32'h600, 32'h0, 2'b10, 1'b0, 32'h1111_2222, 0, 1'b0);

        // Both strobes high, then chip select inactive: neither is an access.
        @(negedge clk);
        cs_d_n = 1'b0; rd = 1'b1; wr = 1'b1; d_addr = 32'h700; whb = 2'b10;
        #1; checkOutput("both_stall", {31'b0, stall}, 32'd0);
        @(negedge clk); #1; checkOutput("both_req", {31'b0, mem_req}, 32'd0);
        cs_d_n = 1'b1; rd = 1'b1; wr = 1'b0;
        #1; checkOutput("nocs_stall", {31'b0, stall}, 32'd0);
        @(negedge clk); #1; checkOutput("nocs_req", {31'b0, mem_req}, 32'd0);
        rd = 1'b0;

        // Reset in the middle of a REQ wait.
        @(negedge clk);
        cs_d_n = 1'b0; rd = 1'b1; wr = 1'b0; d_addr = 32'h500; whb = 2'b10; su = 1'b0; mem_ack = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        checkOutput("rmid_pre_req", {31'b0, mem_req}, 32'd1);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        checkOutput("rmid_req",   {31'b0, mem_req}, 32'd0);
        checkOutput("rmid_stall", {31'b0, stall}, 32'd0);
        cs_d_n = 1'b1; rd = 1'b0;
        @(negedge clk); rst = 1'b1;
        model_dr = 32'h0;
        @(negedge clk); #1;
        checkOutput("rpost_req",   {31'b0, mem_req}, 32'd0);
        checkOutput("rpost_stall", {31'b0, stall}, 32'd0);
        checkOutput("rpost_dread", Data_read, 32'd0);
        applyStimulus("rpost_sb", 1'b1, 32'h11, 32'h0000_0077, 2'b00, 1'b0, 32'h0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory bus controller directly downstream of the MEM stage. Consumes the MEM stage's chip-select, rd/wr strobes, address, store data and width/sign controls (whb, su). Runs a request/acknowledge transaction to a wait-stated data memory, stalling the core until the transaction completes. Performs byte-lane steering for stores and lane extraction plus sign/zero extension for loads, and returns the finished value as Data_read.

Parameters:
TIMEOUT, 16, cycles in REQ without mem_ack before the access is aborted with bus_err (minimum 2).
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  asynchronous, active-low reset.
cs_d_n  in  1  data chip select from MEM, active low.
rd  in  1  load strobe from MEM; any value other than 1 (including z) counts as 0.
wr  in  1  store strobe from MEM; any value other than 1 (including z) counts as 0.
d_addr  in  32  byte address.
Data_write  in  32  store data, right-justified.
whb  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
su  in  1  load extension: 0 sign-extend, 1 zero-extend.
stall  out  1  hold core/MEM inputs stable while 1.
Data_read  out  32  aligned, extended load data to MEM/WB.
misalign  out  1  one-cycle pulse on a misaligned access.
bus_err  out  1  one-cycle pulse on a timeout.
mem_req  out  1  bus request.
mem_we  out  1  1 for a write, 0 for a read.
mem_addr  out  32  word address; bits [1:0] are always 00.
mem_wdata  out  32  lane-replicated store data.
mem_be  out  4  byte enables.
mem_ack  in  1  transaction done; mem_rdata is valid in the same cycle.
mem_rdata  in  32  read word.

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE and the counter clears.
  - All outputs are 0: stall, Data_read, misalign, bus_err, mem_req, mem_we, mem_addr, mem_wdata, mem_be.
  - Reset asserted mid-transaction drops mem_req immediately. The aborted access is not retried.
- Access detect: an access exists when cs_d_n==0 and exactly one of rd/wr ==1. Both strobes at 1, or cs_d_n==1, means no access and no stall.
- Misaligned: half with d_addr[0]=1, or word with d_addr[1:0]!=0.
  - Raises misalign for one cycle. No bus access, no stall, Data_read unchanged.
- States: IDLE, REQ, DONE.
- IDLE:
  - On an aligned access, stall is driven combinationally to 1.
  - Register addr, size, su, we, the steered wdata and the be. Next state is REQ.
  - mem_ack is ignored in IDLE.
- REQ:
  - mem_req=1 with mem_we/addr/wdata/be held stable; stall=1; counter increments each cycle.
  - mem_ack=1 → DONE. For a read, Data_read is updated at that edge.
  - Counter reaches TIMEOUT without ack → DONE with bus_err=1 for one cycle. A timed-out read sets Data_read to 0.
- DONE:
  - stall=0 and mem_req=0; lasts exactly one cycle.
  - Next state is IDLE. A new access is not accepted in DONE.
- Store steering:
  - Byte: wdata={4{Data_write[7:0]}}, be=0001<<addr[1:0].
  - Half: wdata={2{Data_write[15:0]}}, be=addr[1]?1100:0011.
  - Word: wdata=Data_write, be=1111.
- Load extraction:
  - Byte: lane addr[1:0] of mem_rdata.
  - Half: mem_rdata[31:16] if addr[1] else [15:0].
  - Word: the full word.
  - su=0 sign-extends to 32 bits; su=1 zero-extends.
- Data_read holds the last completed load value. Stores never modify it.
- Latency: with ack in the first REQ cycle, stall is high for 2 cycles (IDLE, REQ). Each extra wait cycle adds one.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE, REQ, DONE);
  - the size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the byte-enable constants BE_LO=4'b0011, BE_HI=4'b1100, BE_ALL=4'b1111.
- One combinational sub-module, dmem_lane_align, does store replication, byte-enable generation and load extraction/extension. The top holds the FSM, timeout counter and registers.

Test Plan:
- Word store: addr 0x100, data 0xDEADBEEF, ack in the first REQ cycle → mem_addr 0x100, be 1111, wdata 0xDEADBEEF, stall high for exactly 2 cycles.
- Signed byte load: addr 0x203, su=0, rdata 0x80FF_1234 → Data_read 0xFFFFFF80. Same access with su=1 → 0x00000080.
- Unsigned half load: addr 0x302, su=1, rdata 0xBEEF_0001, ack after 3 wait cycles → Data_read 0x0000BEEF, stall high for 5 cycles, mem signals stable throughout.
- Misaligned: word load at 0x401 → misalign pulse of 1 cycle, mem_req stays 0, stall 0, Data_read unchanged.
- Timeout: read, ack never asserted, TIMEOUT=16 → bus_err pulse after 16 REQ cycles, Data_read 0, stall released in DONE.
- Reset mid-op: rst low during a REQ wait → mem_req/stall go to 0 without waiting for clk; after release the FSM is in IDLE and a new byte store at 0x11 gives be 0010.
